// File: rtl/cflog_pkg.sv
// Shared definitions for the CF-Log streamer: framer state encoding,
// default frame start byte, entry geometry and byte-lane selects.
// Optional checksum stage is controlled by macro CFLOG_STREAM_CSUM_EN.
package cflog_pkg;

  `ifdef CFLOG_STREAM_CSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_CNT, ST_DATA, ST_CSUM} state_t;
  `else
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_CNT, ST_DATA} state_t;
  `endif

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int ENTRY_W = 32;   // {src[15:0], dest[15:0]}
  localparam int LVL_W   = 7;    // occupancy width, holds up to 64

  // Order in which an entry's bytes leave the framer
  localparam logic [1:0] LANE_SRC_HI = 2'd0;
  localparam logic [1:0] LANE_SRC_LO = 2'd1;
  localparam logic [1:0] LANE_DST_HI = 2'd2;
  localparam logic [1:0] LANE_DST_LO = 2'd3;

  // Pick one byte of an entry by lane
  function automatic logic [7:0] entry_byte(input logic [ENTRY_W-1:0] e,
                                            input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      LANE_SRC_HI: b = e[31:24];
      LANE_SRC_LO: b = e[23:16];
      LANE_DST_HI: b = e[15:8];
      default:     b = e[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cflog_stream_if.sv
// Byte-stream handshake carrying CF-Log frames from the framer to a sink.
interface cflog_stream_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cflog_fifo.sv
// CF-Log entry buffer: DEPTH-deep FIFO of 32-bit entries. Pointers wrap
// modulo DEPTH; a separate occupancy count distinguishes full from empty.
module cflog_fifo
  import cflog_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_wdata,
  output logic [ENTRY_W-1:0] o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [LVL_W-1:0]   o_level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Entry storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy; push+pop together leave level unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cflog_stream.sv
// CF-Log streamer: buffers control-flow entries and, on a rising edge of
// flush or ER_done, emits a frame HDR, {overflow,N}, N*4 entry bytes and,
// when CFLOG_STREAM_CSUM_EN is defined, an XOR checksum byte.
module cflog_stream
  import cflog_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cflow_hw_wen,
  input  logic [15:0]      cflow_src,
  input  logic [15:0]      cflow_dest,
  input  logic             flush,
  input  logic             ER_done,
  cflog_stream_if.master   tx,
  output logic             busy,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);
  state_t             r_state, w_state_next;
  logic               r_flush_d, r_er_d, r_armed;
  logic [LVL_W-1:0]   r_cnt, r_rem;
  logic [1:0]         r_lane;
  logic               r_ovf, r_ovf_snap;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full, w_empty;
  logic               w_start, w_xfer, w_pop, w_frame_end, w_drop;
  logic [7:0]         w_tx_data;
  logic               w_tx_valid;
  `ifdef CFLOG_STREAM_CSUM_EN
  logic [7:0]         r_csum;
  `endif

  cflog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (cflow_hw_wen),
    .i_pop   (w_pop),
    .i_wdata ({cflow_src, cflow_dest}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // r_armed blocks a trigger in the first cycle after reset so a level
  // already high at release is not mistaken for a rising edge
  assign w_start  = (r_state == ST_IDLE) & r_armed &
                    ((flush & ~r_flush_d) | (ER_done & ~r_er_d));
  assign w_xfer   = w_tx_valid & tx.tx_ready;
  assign w_drop   = cflow_hw_wen & w_full;
  assign busy     = (r_state != ST_IDLE);
  assign overflow = r_ovf;
  assign tx.tx_data  = w_tx_data;
  assign tx.tx_valid = w_tx_valid;

  // Next-state, pop strobe and byte selection for the frame sequencer
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_frame_end  = 1'b0;
    w_tx_valid   = 1'b1;
    w_tx_data    = 8'h00;
    case (r_state)
      ST_IDLE: begin
        w_tx_valid = 1'b0;
        if (w_start) w_state_next = ST_HDR;
      end
      ST_HDR: begin
        w_tx_data = HDR_BYTE;
        if (w_xfer) w_state_next = ST_CNT;
      end
      ST_CNT: begin
        w_tx_data = {r_ovf_snap, r_cnt[6:0]};
        if (w_xfer) begin
          if (r_cnt != '0) w_state_next = ST_DATA;
          else begin
            `ifdef CFLOG_STREAM_CSUM_EN
            w_state_next = ST_CSUM;
            `else
            w_state_next = ST_IDLE;
            w_frame_end  = 1'b1;
            `endif
          end
        end
      end
      ST_DATA: begin
        w_tx_data = entry_byte(w_head, r_lane);
        if (w_xfer && r_lane == LANE_DST_LO && !w_empty) begin
          w_pop = 1'b1;
          if (r_rem == LVL_W'(1)) begin
            `ifdef CFLOG_STREAM_CSUM_EN
            w_state_next = ST_CSUM;
            `else
            w_state_next = ST_IDLE;
            w_frame_end  = 1'b1;
            `endif
          end
        end
      end
      `ifdef CFLOG_STREAM_CSUM_EN
      ST_CSUM: begin
        w_tx_data = r_csum;
        if (w_xfer) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end
      end
      `endif
      default: begin
        w_tx_valid   = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Edge detectors, frame snapshot, lane/remaining counters and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_d  <= 1'b0;
      r_er_d     <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_lane     <= LANE_SRC_HI;
      r_ovf      <= 1'b0;
      r_ovf_snap <= 1'b0;
    end else begin
      r_flush_d <= flush;
      r_er_d    <= ER_done;
      r_armed   <= 1'b1;
      if (w_start) begin
        // occupancy before any same-cycle push defines N
        r_cnt      <= level;
        r_rem      <= level;
        r_lane     <= LANE_SRC_HI;
        r_ovf_snap <= r_ovf;
      end
      if (w_xfer && r_state == ST_DATA) r_lane <= r_lane + 2'd1;
      if (w_pop) r_rem <= r_rem - LVL_W'(1);
      if (w_drop)           r_ovf <= 1'b1;
      else if (w_frame_end) r_ovf <= 1'b0;
    end
  end

  `ifdef CFLOG_STREAM_CSUM_EN
  // Running XOR over the count byte and all entry bytes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_csum <= 8'h00;
    else if (w_start) r_csum <= 8'h00;
    else if (w_xfer && (r_state == ST_CNT || r_state == ST_DATA))
      r_csum <= r_csum ^ w_tx_data;
  end
  `endif

endmodule

// File: tb/tb_cflog_stream.sv
// Scoreboard bench for cflog_stream: stimulus pushes expected frame bytes
// into a queue, a forked monitor pops and compares on each transfer.
module tb_cflog_stream;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cflow_hw_wen = 1'b0;
  logic [15:0] cflow_src = '0;
  logic [15:0] cflow_dest = '0;
  logic        flush = 1'b0;
  logic        ER_done = 1'b0;
  logic        busy;
  logic [6:0]  level;
  logic        overflow;

  cflog_stream_if bus ();

  cflog_stream #(.DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cflow_hw_wen (cflow_hw_wen),
    .cflow_src    (cflow_src),
    .cflow_dest   (cflow_dest),
    .flush        (flush),
    .ER_done      (ER_done),
    .tx           (bus),
    .busy         (busy),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          rx_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  hand_q[$];
  logic [31:0] model_q[$];
  logic        model_ovf = 1'b0;
  logic        held_vld = 1'b0;
  logic [7:0]  held_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the bench's own entry list
  task automatic build_frame();
    logic [7:0]  b, cs;
    logic [31:0] e;
    int n;
    n = model_q.size();
    exp_q.push_back(8'hA5);
    b = {model_ovf, 7'(n)};
    exp_q.push_back(b);
    cs = b;
    for (int i = 0; i < n; i++) begin
      e = model_q.pop_front();
      for (int k = 3; k >= 0; k--) begin
        b = e[k*8 +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    `ifdef CFLOG_STREAM_CSUM_EN
    exp_q.push_back(cs);
    `endif
    model_ovf = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] s, input logic [15:0] d);
    if (model_q.size() < DEPTH) model_q.push_back({s, d});
    else model_ovf = 1'b1;
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] d);
    cflow_hw_wen = 1'b1;
    cflow_src = s;
    cflow_dest = d;
    model_push(s, d);
    tick();
    cflow_hw_wen = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    build_frame();
    tick();
    flush = 1'b0;
  endtask

  // Wait for frame end; optionally randomise tx_ready and toggle triggers
  task automatic wait_idle(input bit rnd, input bit tog);
    bit done = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      if (tog) begin
        if (i == 2) flush = 1'b1;
        if (i == 3) ER_done = 1'b1;
        if (i == 4) flush = 1'b0;
        if (i == 5) ER_done = 1'b0;
      end
      tick();
      if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
    end
    flush = 1'b0;
    ER_done = 1'b0;
    bus.tx_ready = 1'b1;
    chk("frame_done", 32'(done), 32'd1);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cmp_hand(input string nm);
    chk({nm, "_len"}, 32'(rx_log.size()), 32'(hand_q.size()));
    for (int i = 0; i < hand_q.size() && i < rx_log.size(); i++)
      chk(nm, {24'h0, rx_log[i]}, {24'h0, hand_q[i]});
  endtask

  task automatic set_hand_034();
    hand_q = '{8'hA5, 8'h02, 8'hE0, 8'h00, 8'hE0, 8'h10, 8'hE0, 8'h20, 8'hE1, 8'h00};
    `ifdef CFLOG_STREAM_CSUM_EN
    hand_q.push_back(8'h33);
    `endif
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n && bus.tx_valid) begin
        if (held_vld) chk("hold_stable", {24'h0, bus.tx_data}, {24'h0, held_data});
        if (bus.tx_ready) begin
          $display("tx byte %0d: %h", rx_cnt, bus.tx_data);
          rx_log.push_back(bus.tx_data);
          rx_cnt++;
          held_vld = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %h expected none", bus.tx_data);
          end else begin
            chk("byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
          end
        end else begin
          held_vld = 1'b1;
          held_data = bus.tx_data;
        end
      end else begin
        held_vld = 1'b0;
      end
    end
  endtask

  initial begin
    int base;
    bus.tx_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Flush held high across reset release must not start a frame
    flush = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("no_stale_trig", 32'(busy), 32'd0);
    flush = 1'b0;
    tick();

    // Two-entry frame, sink always ready
    push(16'hE000, 16'hE010);
    push(16'hE020, 16'hE100);
    chk("lvl2", 32'(level), 32'd2);
    rx_log.delete();
    do_flush();
    wait_idle(0, 0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("lvl_after", 32'(level), 32'd0);
    set_hand_034();
    cmp_hand("seq034");

    // Same frame with random backpressure; triggers during frame ignored
    push(16'hE000, 16'hE010);
    push(16'hE020, 16'hE100);
    rx_log.delete();
    do_flush();
    wait_idle(1, 1);
    repeat (4) tick();
    chk("ignored_trig", 32'(busy), 32'd0);
    cmp_hand("seq037");

    // Nine pushes into DEPTH 8: one drop, count byte carries overflow
    for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    chk("lvl_full", 32'(level), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    rx_log.delete();
    do_flush();
    wait_idle(0, 0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("lvl_empty", 32'(level), 32'd0);
    chk("cnt_byte", 32'(rx_log.size() > 1 ? rx_log[1] : 8'hXX), 32'h88);

    // Empty flush
    rx_log.delete();
    do_flush();
    wait_idle(0, 0);
    hand_q = '{8'hA5, 8'h00};
    `ifdef CFLOG_STREAM_CSUM_EN
    hand_q.push_back(8'h00);
    `endif
    cmp_hand("seq036");
    chk("lvl_zero", 32'(level), 32'd0);

    // Push coinciding with the trigger stays for the next frame
    push(16'h1111, 16'h2222);
    rx_log.delete();
    flush = 1'b1;
    cflow_hw_wen = 1'b1;
    cflow_src = 16'h3333;
    cflow_dest = 16'h4444;
    build_frame();
    model_push(16'h3333, 16'h4444);
    tick();
    flush = 1'b0;
    cflow_hw_wen = 1'b0;
    wait_idle(0, 0);
    chk("cnt_one", 32'(rx_log.size() > 1 ? rx_log[1] : 8'hXX), 32'h01);
    chk("lvl_one", 32'(level), 32'd1);
    ER_done = 1'b1;
    build_frame();
    tick();
    ER_done = 1'b0;
    wait_idle(0, 0);
    chk("lvl_zero2", 32'(level), 32'd0);

    // Reset in the middle of the DATA phase
    push(16'hABCD, 16'h1234);
    push(16'h5678, 16'h9ABC);
    base = rx_cnt;
    do_flush();
    for (int i = 0; i < 100 && rx_cnt < base + 4; i++) tick();
    chk("reach_data", 32'(rx_cnt >= base + 4), 32'd1);
    bus.tx_ready = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    exp_q.delete();
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    bus.tx_ready = 1'b1;
    base = rx_cnt;
    repeat (10) tick();
    chk("no_more_bytes", 32'(rx_cnt), 32'(base));
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
